timing_sequencer: RTL

Sequential counterpart of the control-signal generator in the basic computer. It owns the sequence counter (SC), the run/halt flip-flop, the IEN and R interrupt flip-flops, and the input-device flag FGI with its INPR buffer. It consumes the counter and flip-flop commands the control-signal generator emits and returns `state_no`, `op_of_R`, `op_of_ien` and `FGI`, closing the loop between decode and timing.

---
 rtl/basic_computer_pkg.sv | 16 +
 rtl/sc_watchdog.sv | 42 ++++
 rtl/timing_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/basic_computer_pkg.sv
// Shared constants for the basic computer timing path: default widths and
// the named timing states T0..T6 that the sequence counter steps through.
package basic_computer_pkg;

  localparam int SC_W = 4;
  localparam int IN_W = 8;

  localparam logic [3:0] T0 = 4'd0;
  localparam logic [3:0] T1 = 4'd1;
  localparam logic [3:0] T2 = 4'd2;
  localparam logic [3:0] T3 = 4'd3;
  localparam logic [3:0] T4 = 4'd4;
  localparam logic [3:0] T5 = 4'd5;
  localparam logic [3:0] T6 = 4'd6;

endpackage

// File: rtl/sc_watchdog.sv
// Stall counter for the sequence counter: once SC has sat at a non-zero
// state for WDOG_LIMIT cycles it forces SC back to T0 and latches a fault.
module sc_watchdog
  import basic_computer_pkg::*;
#(
  parameter int WDOG_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic force_clr_o,
  output logic sc_fault_o
);

  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  assign force_clr_o = (cnt_q == CNT_W'(WDOG_LIMIT));
  assign sc_fault_o  = fault_q;

  // Forcing SC to T0 is itself a change of SC, so the count restarts then too.
  always_comb begin
    cnt_d   = '0;
    fault_d = fault_q | force_clr_o;
    if (!force_clr_o && stall_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter, run flip-flop, R/IEN interrupt flip-flops and FGI/INPR
// input handshake. Define SC_WATCHDOG_EN to add the SC stall watchdog.
module timing_sequencer #(
  parameter int SC_W       = basic_computer_pkg::SC_W,
  parameter int IN_W       = basic_computer_pkg::IN_W,
  parameter int WDOG_LIMIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  input  logic            inc_controller_counter,
  input  logic            clr_controller_counter,
  input  logic            increment_R,
  input  logic            reset_R,
  input  logic            increment_ien,
  input  logic            reset_ien,
  input  logic            clr_fgi,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic [SC_W-1:0] state_no,
  output logic            op_of_R,
  output logic            op_of_ien,
  output logic            FGI,
  output logic [IN_W-1:0] inpr,
  output logic            run,
  output logic            sc_fault
);
  import basic_computer_pkg::*;

  localparam logic [SC_W-1:0] SC_IDLE = SC_W'(T0);

  logic            run_q, run_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            r_q, r_d;
  logic            ien_q, ien_d;
  logic            fgi_q, fgi_d;
  logic [IN_W-1:0] inpr_q, inpr_d;
  logic            wdog_clr;

`ifdef SC_WATCHDOG_EN
  logic stall;

  // A halt or any SC command moves SC, so those cycles do not count as stalls.
  assign stall = run_q && (sc_q != SC_IDLE) && !inc_controller_counter
                 && !clr_controller_counter && !halt;

  sc_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_sc_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall),
    .force_clr_o (wdog_clr),
    .sc_fault_o  (sc_fault)
  );
`else
  localparam int unused_wdog_limit = WDOG_LIMIT;

  assign wdog_clr = 1'b0;
  assign sc_fault = 1'b0;
`endif

  always_comb begin
    run_d  = run_q;
    sc_d   = sc_q;
    r_d    = r_q;
    ien_d  = ien_q;
    fgi_d  = fgi_q;
    inpr_d = inpr_q;

    if (halt) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
    end

    // Commands are only honoured on the cycle after run is already set.
    if (!run_q || halt || wdog_clr || clr_controller_counter) begin
      sc_d = SC_IDLE;
    end else if (inc_controller_counter) begin
      sc_d = sc_q + SC_W'(1);
    end

    if (run_q) begin
      if (reset_R) begin
        r_d = 1'b0;
      end else if (increment_R) begin
        r_d = 1'b1;
      end
      if (reset_R || reset_ien) begin
        ien_d = 1'b0;
      end else if (increment_ien) begin
        ien_d = 1'b1;
      end
    end

    if (in_valid && !fgi_q) begin
      inpr_d = in_data;
      fgi_d  = 1'b1;
    end else if (clr_fgi) begin
      fgi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      sc_q   <= SC_IDLE;
      r_q    <= 1'b0;
      ien_q  <= 1'b0;
      fgi_q  <= 1'b0;
      inpr_q <= '0;
    end else begin
      run_q  <= run_d;
      sc_q   <= sc_d;
      r_q    <= r_d;
      ien_q  <= ien_d;
      fgi_q  <= fgi_d;
      inpr_q <= inpr_d;
    end
  end

  assign in_ready  = ~fgi_q;
  assign state_no  = sc_q;
  assign op_of_R   = r_q;
  assign op_of_ien = ien_q;
  assign FGI       = fgi_q;
  assign inpr      = inpr_q;
  assign run       = run_q;

endmodule
